quad_gate_emulator: RTL
=======================

Name: quad_gate_emulator

Overview:
- Behavioural model of a 14-pin quad 2-input gate package. It sits on the chip side of the tester pin interface.
- The gate-checker blocks drive the A/B pins. This block answers on the Y pins with a programmable logic function, a programmable output latency, and programmable fault injection.
- Its purpose is closed-loop self-test of the checker FSMs and their pass/fail reporting without a physical chip in the socket.

Parameters:
- DELAY, 1, extra output pipeline stages (0..7) that emulate propagation delay.
- CNT_W, 8, width of the evaluation counter and of the fault trigger threshold.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- Cfg_Valid  input  1  configuration strobe.
- Cfg_Ready  output  1  configuration accept. High in every state except during Reset.
- Cfg_Func  input  3  gate function: 000 NAND, 001 NOR, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 treated as NAND, 111 halt.
- Cfg_Fault_Mode  input  2  00 none, 01 stuck-at-0, 10 stuck-at-1, 11 inverted output.
- Cfg_Fault_Gate  input  2  gate that receives the fault (0..3).
- Cfg_Fault_After  input  CNT_W  number of input-vector changes before the fault arms.
- Pin1, Pin2  input  1  gate 0 inputs A, B.
- Pin4, Pin5  input  1  gate 1 inputs A, B.
- Pin10, Pin9  input  1  gate 2 inputs A, B.
- Pin13, Pin12  input  1  gate 3 inputs A, B.
- Pin3, Pin6, Pin8, Pin11  output  1  Y outputs of gates 0..3.
- Eval_Count  output  CNT_W  input-vector changes seen since the last configuration.
- Fault_Active  output  1  high while in state RUN_FAULT.

Behaviour:
- Reset (asynchronous, any state) sets:
  - State = IDLE.
  - Config to NAND / mode 00 / gate 0 / threshold 0.
  - Vector register, previous-vector register and all pipeline stages to 0.
  - Eval_Count = 0, Fault_Active = 0, all Y pins 0.
- Input sampling: the 8 A/B pins are registered every cycle into Vec. Prev holds the value of Vec from the previous cycle.
- A change event is any cycle with Vec != Prev while State is RUN_CLEAN or RUN_FAULT.
- Function path:
  - The 4-bit Y vector is computed from Vec and passes through DELAY register stages.
  - A pin change is visible on Y after 1+DELAY rising edges. DELAY=0 means Y is combinational from Vec.
- Fault path:
  - Applied to gate Cfg_Fault_Gate before the pipeline, only in RUN_FAULT.
  - Mode 01 forces that gate's Y to 0, mode 10 forces it to 1, mode 11 inverts it.
  - The other three gates are never affected.
- State IDLE:
  - All Y pins forced 0 at the output, regardless of pipeline contents.
  - Eval_Count holds its value.
- Configuration accept: Cfg_Valid & Cfg_Ready, in any state.
  - Func 111: go to IDLE; config is not latched.
  - Otherwise: latch all Cfg_* fields and clear Eval_Count.
  - Next state is RUN_FAULT if mode != 00 and threshold == 0; otherwise RUN_CLEAN.
  - The pipeline is not flushed: in-flight samples still emerge with the old function.
  - An accept in the same cycle as a change event: the accept wins, count becomes 0 and the event is dropped.
- State RUN_CLEAN:
  - Each change event increments Eval_Count, saturating at all-ones.
  - If mode != 00 and the incremented count equals the threshold, go to RUN_FAULT on that same edge.
  - The fault then applies to every Vec registered from that edge onward.
- State RUN_FAULT:
  - Counting continues with saturation.
  - Stays here until a new configuration is accepted or Reset.
- A threshold that is never reached (saturating count below it, or mode 00) keeps the block in RUN_CLEAN indefinitely.

Optional Feature:
- Macro: QUAD_GATE_PIN_SYNC_EN.
- When defined: each of the 8 input pins passes through a 2-flop synchronizer before Vec. Pin-to-Y latency becomes 3+DELAY edges; the change-event definition is unchanged; synchronizer flops reset to 0.
- When undefined: pins feed Vec directly and latency is 1+DELAY.

Test Plan:
- Reset, then configure NAND/mode 00 with DELAY=1. Drive all four gate input pairs together to AB=00,01,10,11, holding each 3 cycles. Each Y must equal 1,1,1,0, appearing 2 edges after the pins change. Fault_Active = 0 and Eval_Count = 3.
- Configure XOR with stuck-at-1 on gate 2 and threshold 2. Step the vectors 00→01→10→11. Fault_Active must rise on the edge where the 2nd change is counted. Pin8 must stay 1 for all later vectors, including 11. Pin3/Pin6/Pin11 must read 0 for vector 11.
- Configure NOR with mode 11 on gate 0 and threshold 0. Fault_Active must be 1 on the next edge. Pin3 must read the inverted NOR: 0 for AB=00 and 1 for AB=11.
- CNT_W=2: configure a fault with threshold 3 and drive 6 changes. Eval_Count must saturate at 3 and Fault_Active must assert at the 3rd change.
- Mid-run, configure Func=111: the next edge enters IDLE, all Y pins 0, Eval_Count frozen. Then configure AND in the same cycle as a pin change: Eval_Count must be 0 after the edge.
- Assert Reset asynchronously between edges while in RUN_FAULT: Y pins, Fault_Active and Eval_Count must go to 0 immediately, before the next Clk edge.

Source files
------------

// File: rtl/quad_gate_emulator.sv
// Behavioural stand-in for a 14-pin quad 2-input gate chip on the tester pins.
// Optional macro QUAD_GATE_PIN_SYNC_EN adds a 2-flop synchronizer on every input pin.

module quad_gate_lane (
    input  logic       a,
    input  logic       b,
    input  logic [2:0] func,
    input  logic       fault_en,
    input  logic [1:0] fault_mode,
    output logic       y
);
    logic f;

    always_comb begin
        f = 1'b0;
        case (func)
            3'b000:  f = ~(a & b);
            3'b001:  f = ~(a | b);
            3'b010:  f = a & b;
            3'b011:  f = a | b;
            3'b100:  f = a ^ b;
            3'b101:  f = ~(a ^ b);
            3'b110:  f = ~(a & b);
            default: f = 1'b0;
        endcase
        y = f;
        if (fault_en) begin
            case (fault_mode)
                2'b01:   y = 1'b0;
                2'b10:   y = 1'b1;
                2'b11:   y = ~f;
                default: y = f;
            endcase
        end
    end
endmodule

module quad_gate_emulator #(
    parameter int DELAY = 1,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Cfg_Valid,
    output logic             Cfg_Ready,
    input  logic [2:0]       Cfg_Func,
    input  logic [1:0]       Cfg_Fault_Mode,
    input  logic [1:0]       Cfg_Fault_Gate,
    input  logic [CNT_W-1:0] Cfg_Fault_After,
    input  logic             Pin1,
    input  logic             Pin2,
    input  logic             Pin4,
    input  logic             Pin5,
    input  logic             Pin10,
    input  logic             Pin9,
    input  logic             Pin13,
    input  logic             Pin12,
    output logic             Pin3,
    output logic             Pin6,
    output logic             Pin8,
    output logic             Pin11,
    output logic [CNT_W-1:0] Eval_Count,
    output logic             Fault_Active
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, RUN_CLEAN, RUN_FAULT} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             func_q, func_d;
    logic [1:0]             mode_q, mode_d;
    logic [1:0]             gate_q, gate_d;
    logic [CNT_W-1:0]       thr_q, thr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [2*NUM_LANES-1:0] pin_vec, vec_q, vec_d, prev_q;
    logic                   accept, change;

    logic [NUM_LANES-1:0]   lane_a, lane_b, lane_fault, y_comb, y_pipe;

    // Lane g uses A = vec[2g], B = vec[2g+1]
    always_comb pin_vec = {Pin12, Pin13, Pin9, Pin10, Pin5, Pin4, Pin2, Pin1};

`ifdef QUAD_GATE_PIN_SYNC_EN
    logic [2*NUM_LANES-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = pin_vec;
        sync2_d = sync1_q;
        vec_d   = sync2_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end
`else
    always_comb vec_d = pin_vec;
`endif

    assign Cfg_Ready = ~Reset;
    assign accept    = Cfg_Valid & Cfg_Ready;
    assign change    = (vec_q != prev_q) && (state_q != IDLE);
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        mode_d  = mode_q;
        gate_d  = gate_q;
        thr_d   = thr_q;
        cnt_d   = cnt_q;
        // A config accept takes priority over a coincident change event
        if (accept) begin
            if (Cfg_Func == 3'b111) begin
                state_d = IDLE;
            end else begin
                func_d  = Cfg_Func;
                mode_d  = Cfg_Fault_Mode;
                gate_d  = Cfg_Fault_Gate;
                thr_d   = Cfg_Fault_After;
                cnt_d   = '0;
                state_d = (Cfg_Fault_Mode != 2'b00 && Cfg_Fault_After == '0) ? RUN_FAULT : RUN_CLEAN;
            end
        end else if (change) begin
            cnt_d = cnt_inc;
            if (state_q == RUN_CLEAN && mode_q != 2'b00 && cnt_inc == thr_q)
                state_d = RUN_FAULT;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            func_q  <= 3'b000;
            mode_q  <= 2'b00;
            gate_q  <= 2'b00;
            thr_q   <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            mode_q  <= mode_d;
            gate_q  <= gate_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            prev_q  <= vec_q;
        end
    end

    always_comb begin
        for (int g = 0; g < NUM_LANES; g++) begin
            lane_a[g]     = vec_q[2*g];
            lane_b[g]     = vec_q[2*g+1];
            lane_fault[g] = (state_q == RUN_FAULT) && (gate_q == 2'(g));
        end
    end

    quad_gate_lane u_lane [NUM_LANES-1:0] (
        .a          (lane_a),
        .b          (lane_b),
        .func       ({NUM_LANES{func_q}}),
        .fault_en   (lane_fault),
        .fault_mode ({NUM_LANES{mode_q}}),
        .y          (y_comb)
    );

    // Propagation-delay pipeline; not flushed on reconfiguration
    generate
        if (DELAY == 0) begin : g_nopipe
            assign y_pipe = y_comb;
        end else begin : g_pipe
            logic [DELAY-1:0][NUM_LANES-1:0] pipe_q, pipe_d;

            always_comb begin
                pipe_d[0] = y_comb;
                for (int i = 1; i < DELAY; i++) pipe_d[i] = pipe_q[i-1];
            end

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) pipe_q <= '0;
                else       pipe_q <= pipe_d;
            end

            assign y_pipe = pipe_q[DELAY-1];
        end
    endgenerate

    logic [NUM_LANES-1:0] y_out;
    assign y_out        = (state_q == IDLE) ? '0 : y_pipe;
    assign Pin3         = y_out[0];
    assign Pin6         = y_out[1];
    assign Pin8         = y_out[2];
    assign Pin11        = y_out[3];
    assign Eval_Count   = cnt_q;
    assign Fault_Active = (state_q == RUN_FAULT);
endmodule
